serial_subtractor: RTL

//  Bit-serial W-bit subtractor: diff = a - b - bin, one bit per cycle, LSB first.

---
 rtl/serial_subtractor_if.sv | 49 ++++
 rtl/serial_subtractor.sv | 135 +++++++++++++
 2 files changed

// File: rtl/serial_subtractor_if.sv
// -----------------------------------------------------------------------------
// serial_subtractor_if
// Purpose : Groups the operand/result handshake and data signals of the
//           bit-serial subtractor into one bundle.
// Handshake: a transfer happens only on a rising clk edge where valid && ready.
//            The producer holds valid and its data stable until that edge.
//            The consumer may change ready at any time. in_valid has no effect
//            outside IDLE, and out_ready has no effect outside DONE.
// Signals : in_valid/in_ready/a/b/bin    operand channel
//           out_valid/out_ready/diff/bout result channel
//           busy                          high while bits are being processed
//           ovf                           signed overflow (only with SUB_OVF_EN)
// Modports: master -- environment side (drives operands, consumes results)
//           slave  -- subtractor side
// Config  : `define SUB_OVF_EN adds the ovf signal.
// -----------------------------------------------------------------------------
interface serial_subtractor_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             bin;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] diff;
   logic             bout;
   logic             busy;
`ifdef SUB_OVF_EN
   logic             ovf;
`endif

   modport master (
      output in_valid, a, b, bin, out_ready,
      input  in_ready, out_valid, diff, bout, busy
`ifdef SUB_OVF_EN
      , input ovf
`endif
   );

   modport slave (
      input  in_valid, a, b, bin, out_ready,
      output in_ready, out_valid, diff, bout, busy
`ifdef SUB_OVF_EN
      , output ovf
`endif
   );
endinterface

// File: rtl/serial_subtractor.sv
// -----------------------------------------------------------------------------
// serial_subtractor
// Purpose : Bit-serial WIDTH-bit subtractor. It computes diff = a - b - bin one
//           bit per cycle, LSB first, using a full-subtractor cell and a borrow
//           flip-flop.
// Ports   : clk        rising-edge clock
//           rst_n      asynchronous active-low reset
//           bus        serial_subtractor_if.slave (operand/result handshakes,
//                      busy, and ovf when enabled)
//           dbg_state  current FSM state (0 IDLE, 1 RUN, 2 DONE)
// Timing  : the operands are accepted in IDLE. RUN then takes exactly WIDTH
//           edges. DONE holds out_valid, diff and bout until out_ready.
// Config  : `define SUB_OVF_EN enables ovf. The sign bits of a and b are
//           captured at accept, and ovf is computed from them in DONE.
// -----------------------------------------------------------------------------
module serial_subtractor #(
   parameter int WIDTH = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   serial_subtractor_if.slave  bus,
   output logic [1:0]          dbg_state
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic [WIDTH-1:0] a_sr;
   logic [WIDTH-1:0] b_sr;
   logic [WIDTH-1:0] diff_r;
   logic             brw;
   logic [CW-1:0]    cnt;
   logic             d_bit;
   logic             brw_nxt;
   logic             last_bit;
`ifdef SUB_OVF_EN
   logic             a_sgn;
   logic             b_sgn;
`endif

   // Full-subtractor cell operating on the current LSBs.
   assign d_bit    = a_sr[0] ^ b_sr[0] ^ brw;
   assign brw_nxt  = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
   assign last_bit = (cnt == CW'(WIDTH - 1));

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic and handshake outputs.
   always_comb begin
      state_nxt     = state;
      bus.in_ready  = 1'b0;
      bus.busy      = 1'b0;
      bus.out_valid = 1'b0;
      unique case (state)
         IDLE: begin
            bus.in_ready = 1'b1;
            if (bus.in_valid) state_nxt = RUN;
         end
         RUN: begin
            bus.busy = 1'b1;
            if (last_bit) state_nxt = DONE;
         end
         DONE: begin
            bus.out_valid = 1'b1;
            if (bus.out_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Datapath: shift registers, borrow FF and bit counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_sr   <= '0;
         b_sr   <= '0;
         diff_r <= '0;
         brw    <= 1'b0;
         cnt    <= '0;
`ifdef SUB_OVF_EN
         a_sgn  <= 1'b0;
         b_sgn  <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (bus.in_valid) begin
                  a_sr   <= bus.a;
                  b_sr   <= bus.b;
                  brw    <= bus.bin;
                  cnt    <= '0;
                  diff_r <= '0;
`ifdef SUB_OVF_EN
                  a_sgn  <= bus.a[WIDTH-1];
                  b_sgn  <= bus.b[WIDTH-1];
`endif
               end
            end
            RUN: begin
               // The result fills from the MSB side. After WIDTH shifts, the
               // first (LSB) difference bit has reached bit 0.
               a_sr   <= a_sr >> 1;
               b_sr   <= b_sr >> 1;
               diff_r <= {d_bit, diff_r[WIDTH-1:1]};
               brw    <= brw_nxt;
               cnt    <= cnt + CW'(1);
            end
            default: begin
               // DONE holds the result stable while the output stalls.
            end
         endcase
      end
   end

   // The final borrow lives in the borrow FF, which is frozen outside RUN.
   assign bus.diff = diff_r;
   assign bus.bout = brw;
   assign dbg_state = state;

`ifdef SUB_OVF_EN
   assign bus.ovf = (state == DONE) && (a_sgn != b_sgn) && (diff_r[WIDTH-1] != a_sgn);
`endif
endmodule
